stm_gain_reader: RTL and testbench
==================================

Name: stm_gain_reader

Overview:
- Downstream consumer of the gain-STM BRAM read port (512-bit rows, 32 x 16-bit transducer words per row, 8 rows per pattern).
- On a start request for a pattern index, it fetches that pattern's 8 rows and serialises them into a per-transducer stream: one intensity/phase pair per cycle.
- The stream feeds the modulation/duty stage. Row fetches are prefetched, so the output stream has no bubbles.

Parameters:
- NUM_TRANS, 249, transducers emitted per pattern (1..256).
- IDX_WIDTH, 10, pattern index width; ROW_ADDR_WIDTH = IDX_WIDTH + 3.
- RD_LATENCY, 2, cycles from ADDRB change to valid DOUTB (1..16).

Ports:
- CLK  in  1  system clock; same clock as the BRAM port-B clock.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request pulse.
- IDX  in  IDX_WIDTH  pattern index, sampled when START is accepted.
- BUSY  out  1  high while a pattern read is in progress.
- ADDRB  out  ROW_ADDR_WIDTH  BRAM row address, registered.
- DOUTB  in  512  BRAM row data.
- DOUT_VALID  out  1  stream valid.
- TR_IDX  out  8  transducer index of the current output.
- INTENSITY  out  8  word bits [15:8].
- PHASE  out  8  word bits [7:0].
- DONE  out  1  one-cycle pulse after the last transducer.

Behaviour:
- Reset (async assert, sync release): state IDLE; every output is 0, including ADDRB, BUSY, DOUT_VALID, TR_IDX, INTENSITY, PHASE and DONE. Internal counters and row registers are also 0.
- Word mapping: transducer t is at row t>>5, lane t&31, data DOUTB[16*lane +: 16]. Row address = {IDX, t>>5}.
- FSM states:
  - IDLE: START accepted -> latch IDX, set ADDRB = {IDX,3'd0}, BUSY=1 in the next cycle, go to FETCH.
  - FETCH: wait RD_LATENCY cycles after the ADDRB change, capture DOUTB into the row shift register, go to STREAM.
  - STREAM: emit one transducer per cycle.
    - Prefetch: row r+1 address is issued so that its data is valid exactly when lane 31 of row r is emitted. It is captured on the cycle after lane 31, giving no gap.
    - With RD_LATENCY > 31 a gap would be unavoidable; this is disallowed by the parameter range.
    - After TR_IDX = NUM_TRANS-1 is emitted, go to DONE_S.
  - DONE_S: DONE=1 and BUSY=0 for one cycle, DOUT_VALID=0, then IDLE.
- Latency: if START is sampled in cycle 0, ADDRB updates in cycle 1 and the first DOUT_VALID appears in cycle RD_LATENCY+2.
  - DOUT_VALID is then high for exactly NUM_TRANS consecutive cycles.
  - TR_IDX runs 0..NUM_TRANS-1, incrementing by 1 each valid cycle.
- Rows beyond ceil(NUM_TRANS/32) are never addressed. A partial last row emits only its low lanes.
- START while BUSY=1, or in the DONE_S cycle, is ignored: no restart, no queueing.
- Outputs while DOUT_VALID=0: INTENSITY, PHASE and TR_IDX hold 0.
- ADDRB holds its last value when idle.
- Reset mid-stream: immediate return to reset values; a following START begins a clean read.
- IDX at its maximum (2^IDX_WIDTH-1): row addresses reach all-ones with no wrap into pattern 0.
- Arithmetic: the row counter is 3 bits and the lane counter 5 bits. TR_IDX = {row, lane}, truncated to 8 bits.

Test Plan:
- BRAM model (RD_LATENCY=2) filled so that word = {t[7:0], ~t[7:0]} for pattern 5. START with IDX=5 in cycle 0 -> ADDRB=40 in cycle 1. DOUT_VALID is high in cycles 4..252 (249 cycles), with INTENSITY=t and PHASE=~t. DONE pulses in cycle 253.
- Same stimulus with RD_LATENCY=1 and RD_LATENCY=16 -> first valid in cycles 3 and 18 respectively. No gaps occur, and ADDRB sequence is 40..47.
- START with IDX=1023 -> ADDRB runs 8184..8191 and data is correct. ADDRB never reaches 0.
- Extra START pulses 10 and 100 cycles after the first -> ignored. Exactly one 249-cycle stream and one DONE.
- RST_N asserted at transducer 100 -> all outputs 0 immediately. A START with IDX=2 after release -> full clean stream from TR_IDX=0 with pattern-2 data.
- NUM_TRANS=32 -> only row {IDX,0} is addressed. The stream is 32 cycles, followed by DONE.

Source files
------------

// File: rtl/stm_gain_reader.sv
`default_nettype none
// ============================================================================
// stm_gain_reader : fetches the rows of one gain-STM pattern from the BRAM and
//                   serialises them into a gapless per-transducer stream.
// Revision 1.0
// ============================================================================
module stm_gain_reader #(
    parameter int NUM_TRANS  = 249,
    parameter int IDX_WIDTH  = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    input  logic [IDX_WIDTH-1:0]    IDX,
    output logic                    BUSY,
    output logic [IDX_WIDTH+2:0]    ADDRB,
    input  logic [511:0]            DOUTB,
    output logic                    DOUT_VALID,
    output logic [7:0]              TR_IDX,
    output logic [7:0]              INTENSITY,
    output logic [7:0]              PHASE,
    output logic                    DONE
);

    localparam int ROW_ADDR_WIDTH = IDX_WIDTH + 3;

    localparam logic [4:0] c_lat      = 5'(RD_LATENCY);
    // Issuing the next row address at this lane makes its data land exactly
    // on lane 31 of the current row.
    localparam logic [4:0] c_pf_lane  = 5'(30 - RD_LATENCY);
    localparam logic [2:0] c_last_row = 3'((NUM_TRANS - 1) / 32);
    localparam logic [7:0] c_last_tr  = 8'(NUM_TRANS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE_S = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_WIDTH-1:0]       idx_q, idx_d;
    logic [ROW_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [4:0]                 wait_q, wait_d;
    logic [2:0]                 row_q, row_d;
    logic [4:0]                 lane_q, lane_d;
    logic [511:0]               shreg_q, shreg_d;

    logic [2:0]                 w_row_nxt;
    logic [7:0]                 w_tr;
    logic                       w_valid;

    assign w_row_nxt = row_q + 3'd1;
    assign w_tr      = {row_q, lane_q};
    assign w_valid   = (state_q == STREAM);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        row_d   = row_q;
        lane_d  = lane_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    idx_d   = IDX;
                    addr_d  = {IDX, 3'd0};
                    wait_d  = 5'd0;
                    row_d   = 3'd0;
                    lane_d  = 5'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (wait_q == c_lat) begin
                    shreg_d = DOUTB;
                    state_d = STREAM;
                end else begin
                    wait_d = wait_q + 5'd1;
                end
            end
            STREAM: begin
                shreg_d = {16'd0, shreg_q[511:16]};
                lane_d  = lane_q + 5'd1;
                if (lane_q == c_pf_lane && row_q != c_last_row) begin
                    addr_d = {idx_q, w_row_nxt};
                end
                // Prefetched row is valid on the DOUTB bus during lane 31.
                if (lane_q == 5'd31) begin
                    row_d   = w_row_nxt;
                    shreg_d = DOUTB;
                end
                if (w_tr == c_last_tr) begin
                    state_d = DONE_S;
                end
            end
            DONE_S: begin
                row_d   = 3'd0;
                lane_d  = 5'd0;
                wait_d  = 5'd0;
                shreg_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wait_q  <= '0;
            row_q   <= '0;
            lane_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            row_q   <= row_d;
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
        end
    end

    assign ADDRB      = addr_q;
    assign BUSY       = (state_q == FETCH) || (state_q == STREAM);
    assign DOUT_VALID = w_valid;
    assign DONE       = (state_q == DONE_S);
    assign TR_IDX     = w_valid ? w_tr : 8'd0;
    assign INTENSITY  = w_valid ? shreg_q[15:8] : 8'd0;
    assign PHASE      = w_valid ? shreg_q[7:0] : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_stm_gain_reader.sv
`default_nettype none
// ============================================================================
// tb_stm_gain_reader : four readers (latency 2/1/16 with 249 transducers,
//                      latency 2 with 32) share one stimulus and reset.
// Revision 1.0
// ============================================================================
module tb_stm_gain_reader;

    localparam int NI = 4;

    typedef struct {
        longint     tm;
        logic [7:0] tr;
        logic [7:0] inten;
        logic [7:0] ph;
    } beat_t;

    typedef struct {
        logic [9:0] idx;
        int         p2;
        int         p3;
        int         dl;
        int         ds;
        int         vl;
        int         vs;
    } vec_t;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic [9:0] IDX   = '0;

    int checks = 0;
    int errors = 0;

    int done_cnt  [NI];
    int valid_cnt [NI];
    int busy_m    [NI];
    int pend      [NI];

    logic         busy_w  [NI];
    logic         valid_w [NI];
    logic         done_w  [NI];
    logic [12:0]  addr_w  [NI];
    logic [511:0] dout_w  [NI];
    logic [7:0]   tr_w    [NI];
    logic [7:0]   int_w   [NI];
    logic [7:0]   ph_w    [NI];

    always #5 CLK = ~CLK;

    // Pattern p, transducer t: intensity = t ^ (p-5), phase = ~intensity.
    function automatic logic [511:0] row_data(input logic [12:0] a);
        logic [511:0] d;
        logic [7:0]   t;
        logic [7:0]   iv;
        d = '0;
        for (int l = 0; l < 32; l++) begin
            t  = {a[2:0], 5'(l)};
            iv = t ^ 8'(a[12:3] - 10'd5);
            d[16*l +: 16] = {iv, ~iv};
        end
        return d;
    endfunction

    task automatic chk(input string name, input int g, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d expected %0d", name, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L    = (g == 1) ? 1 : (g == 2) ? 16 : 2;
        localparam int N    = (g == 3) ? 32 : 249;
        localparam int ROWS = (N - 1) / 32 + 1;

        beat_t       beats[$];
        longint      done_q[$];
        logic [12:0] addr_q[$];
        logic [12:0] pipe [0:15];
        logic [12:0] prev_addr = '0;
        longint      busy_lo = -1;
        longint      busy_hi = -1;
        longint      t0;
        longint      tn;
        beat_t       b;
        logic [7:0]  ei;

        stm_gain_reader #(
            .NUM_TRANS (N),
            .IDX_WIDTH (10),
            .RD_LATENCY(L)
        ) u_dut (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .START     (START),
            .IDX       (IDX),
            .BUSY      (busy_w[g]),
            .ADDRB     (addr_w[g]),
            .DOUTB     (dout_w[g]),
            .DOUT_VALID(valid_w[g]),
            .TR_IDX    (tr_w[g]),
            .INTENSITY (int_w[g]),
            .PHASE     (ph_w[g]),
            .DONE      (done_w[g])
        );

        always @(posedge CLK) begin
            pipe[0] <= addr_w[g];
            for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
        end
        assign dout_w[g] = row_data(pipe[L-1]);

        // Acceptance model: pushes the expected stream when a START is taken.
        always @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                beats.delete();
                done_q.delete();
                addr_q.delete();
                busy_m[g] = 0;
                busy_lo   = -1;
                busy_hi   = -1;
            end else if (busy_m[g] == 0 && START) begin
                t0 = $time;
                busy_m[g] = L + N + 2;
                for (int r = 0; r < ROWS; r++) begin
                    if (!(r == 0 && {IDX, 3'd0} == prev_addr))
                        addr_q.push_back({IDX, 3'(r)});
                end
                for (int t = 0; t < N; t++) begin
                    ei      = 8'(t) ^ 8'(IDX - 10'd5);
                    b.tm    = t0 - 5 + 10 * longint'(L + 2 + t);
                    b.tr    = 8'(t);
                    b.inten = ei;
                    b.ph    = ~ei;
                    beats.push_back(b);
                end
                done_q.push_back(t0 - 5 + 10 * longint'(L + 2 + N));
                busy_lo = t0 + 5;
                busy_hi = t0 - 5 + 10 * longint'(L + 1 + N);
            end else if (busy_m[g] > 0) begin
                busy_m[g] = busy_m[g] - 1;
            end
        end

        always @(negedge CLK) begin
            tn = $time;
            if (!RST_N) begin
                chk("reset_outputs", g,
                    longint'({busy_w[g], valid_w[g], done_w[g], tr_w[g], int_w[g], ph_w[g], addr_w[g]}), 0);
                prev_addr = '0;
            end else begin
                chk("busy", g, longint'(busy_w[g]), longint'(tn >= busy_lo && tn <= busy_hi));
                if (addr_w[g] != prev_addr) begin
                    if (addr_q.size() == 0) chk("addrb_unexpected", g, longint'(addr_w[g]), longint'(prev_addr));
                    else chk("addrb_seq", g, longint'(addr_w[g]), longint'(addr_q.pop_front()));
                    prev_addr = addr_w[g];
                end
                if (valid_w[g]) begin
                    valid_cnt[g]++;
                    if (beats.size() == 0) begin
                        chk("valid_unexpected", g, longint'(valid_w[g]), 0);
                    end else begin
                        b = beats.pop_front();
                        chk("valid_time", g, tn, b.tm);
                        chk("tr_idx", g, longint'(tr_w[g]), longint'(b.tr));
                        chk("intensity", g, longint'(int_w[g]), longint'(b.inten));
                        chk("phase", g, longint'(ph_w[g]), longint'(b.ph));
                    end
                end else begin
                    chk("idle_data_zero", g, longint'({tr_w[g], int_w[g], ph_w[g]}), 0);
                end
                if (done_w[g]) begin
                    done_cnt[g]++;
                    if (done_q.size() == 0) chk("done_unexpected", g, longint'(done_w[g]), 0);
                    else chk("done_time", g, tn, done_q.pop_front());
                end
            end
            pend[g] = beats.size() + done_q.size() + addr_q.size();
        end
    end

    task automatic run_vec(input vec_t v);
        int d0 [NI];
        int v0 [NI];
        int to;
        for (int g = 0; g < NI; g++) begin
            d0[g] = done_cnt[g];
            v0[g] = valid_cnt[g];
        end
        @(posedge CLK); #1 START = 1'b1; IDX = v.idx;
        @(posedge CLK); #1 START = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            if (c == v.p2 || c == v.p3) begin
                START = 1'b1;
                IDX   = v.idx ^ 10'd1;
            end
            @(posedge CLK); #1 START = 1'b0;
        end
        to = 0;
        while ((busy_m[0] | busy_m[1] | busy_m[2] | busy_m[3]) != 0 && to < 2000) begin
            @(posedge CLK);
            to++;
        end
        chk("idle_timeout", 0, longint'(to < 2000), 1);
        repeat (2) @(negedge CLK);
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("done_count", g, done_cnt[g] - d0[g], (g == 3) ? v.ds : v.dl);
            chk("valid_count", g, valid_cnt[g] - v0[g], (g == 3) ? v.vs : v.vl);
            chk("pending_expect", g, pend[g], 0);
            chk("busy_after", g, longint'(busy_w[g]), 0);
        end
    endtask

    initial begin
        vec_t vecs [4];
        vec_t post;
        int   to;
        vecs[0] = '{10'd5,    0,   0, 1, 1, 249, 32};
        vecs[1] = '{10'd1023, 0,   0, 1, 1, 249, 32};
        vecs[2] = '{10'd5,    10, 100, 1, 2, 249, 64};
        vecs[3] = '{10'd7,    0,   0, 1, 1, 249, 32};
        post    = '{10'd2,    0,   0, 1, 1, 249, 32};
        for (int g = 0; g < NI; g++) begin
            done_cnt[g]  = 0;
            valid_cnt[g] = 0;
            busy_m[g]    = 0;
            pend[g]      = 0;
        end

        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (2) @(posedge CLK);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Reset in the middle of a stream, then a clean read of pattern 2.
        @(posedge CLK); #1 START = 1'b1; IDX = 10'd5;
        @(posedge CLK); #1 START = 1'b0;
        to = 0;
        do begin
            @(negedge CLK);
            to++;
        end while (!(valid_w[0] && tr_w[0] == 8'd100) && to < 500);
        chk("reach_tr100", 0, longint'(to < 500), 1);
        #2 RST_N = 1'b0;
        #1;
        for (int g = 0; g < NI; g++)
            chk("reset_immediate", g,
                longint'({busy_w[g], valid_w[g], done_w[g], tr_w[g], int_w[g], ph_w[g], addr_w[g]}), 0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        run_vec(post);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
